// File: rtl/multi_ch_sample_packer.sv
// Multi-channel ADC frame capture: frames go through a small FIFO and are
// serialized onto an AXI-Stream, channel 0 LSB first.
module multi_ch_sample_packer #(
  parameter int CH_NUM     = 4,
  parameter int SAMPLE_W   = 16,
  parameter int AXIS_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                       adc_clk,
  input  logic                       adc_rst,
  input  logic [CH_NUM*SAMPLE_W-1:0] adc_data,
  input  logic                       adc_valid,
  input  logic [31:0]                sample_len,
  input  logic                       sample_start,
  input  logic                       test_mode,
  output logic                       st_clr,
  output logic                       done,
  output logic                       overflow,
  output logic [15:0]                drop_cnt,
  output logic [AXIS_W-1:0]          DMA_AXIS_tdata,
  output logic [AXIS_W/8-1:0]        DMA_AXIS_tkeep,
  output logic                       DMA_AXIS_tlast,
  output logic                       DMA_AXIS_tvalid,
  input  logic                       DMA_AXIS_tready
);
  localparam int FRAME_W = CH_NUM * SAMPLE_W;
  localparam int BPF     = FRAME_W / AXIS_W;
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW      = (BPF > 1) ? $clog2(BPF) : 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [31:0]         len_q;
  logic [31:0]         acc_cnt;
  logic                tmode_q;
  logic [SAMPLE_W-1:0] ramp;

  logic [FRAME_W:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         fifo_cnt;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_rd;

  logic                start_ok;
  logic                frame_in;
  logic                frame_drop;
  logic                last_tag;
  logic [FRAME_W-1:0]  frame_p0;

  logic [FRAME_W-1:0]  sdata_p1;
  logic                slast_p1;
  logic                vld_p1;
  logic [BW-1:0]       beat_p1;
  logic                final_beat;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage p0: frame selection and FIFO admission
  always_comb begin
    frame_p0 = adc_data;
    if (tmode_q) begin
      for (int c = 0; c < CH_NUM; c++)
        frame_p0[c*SAMPLE_W +: SAMPLE_W] = ramp + SAMPLE_W'(c);
    end
  end

  assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign start_ok   = (state == IDLE) && sample_start && (sample_len != 32'd0);
  assign frame_in   = (state == SAMPLE) && adc_valid && !fifo_full;
  assign frame_drop = (state == SAMPLE) && adc_valid && fifo_full;
  assign last_tag   = (acc_cnt == len_q - 32'd1);
  assign final_beat = vld_p1 && DMA_AXIS_tready && (beat_p1 == BW'(BPF-1));
  assign fifo_rd    = !fifo_empty && (!vld_p1 || final_beat);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:    if (start_ok) state_nxt = SAMPLE;
      SAMPLE:  if (frame_in && last_tag) state_nxt = DRAIN;
      DRAIN: begin
        if (fifo_empty && !vld_p1) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      len_q    <= 32'd0;
      tmode_q  <= 1'b0;
      acc_cnt  <= 32'd0;
      ramp     <= '0;
      overflow <= 1'b0;
      drop_cnt <= 16'd0;
    end else if (start_ok) begin
      len_q    <= sample_len;
      tmode_q  <= test_mode;
      acc_cnt  <= 32'd0;
      ramp     <= '0;
      overflow <= 1'b0;
      drop_cnt <= 16'd0;
    end else begin
      if (frame_in) begin
        acc_cnt <= acc_cnt + 32'd1;
        ramp    <= ramp + SAMPLE_W'(1);
      end
      if (frame_drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc16(drop_cnt);
      end
    end
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (frame_in) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_rd)  rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt <= fifo_cnt + (AW+1)'(frame_in) - (AW+1)'(fifo_rd);
    end
  end

  always_ff @(posedge adc_clk) begin
    if (frame_in) fifo_mem[wr_ptr] <= {last_tag, frame_p0};
  end

  // Stage p1: serializer holding one frame, shifted out AXIS_W bits per beat
  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      vld_p1   <= 1'b0;
      beat_p1  <= '0;
      slast_p1 <= 1'b0;
    end else if (fifo_rd) begin
      vld_p1   <= 1'b1;
      beat_p1  <= '0;
      slast_p1 <= fifo_mem[rd_ptr][FRAME_W];
    end else if (vld_p1 && DMA_AXIS_tready) begin
      if (final_beat) vld_p1 <= 1'b0;
      else            beat_p1 <= beat_p1 + BW'(1);
    end
  end

  always_ff @(posedge adc_clk) begin
    if (fifo_rd)
      sdata_p1 <= fifo_mem[rd_ptr][FRAME_W-1:0];
    else if (vld_p1 && DMA_AXIS_tready)
      sdata_p1 <= sdata_p1 >> AXIS_W;
  end

  // Data register is not reset, so the bus is gated by the valid flag
  assign DMA_AXIS_tvalid = vld_p1;
  assign DMA_AXIS_tdata  = vld_p1 ? sdata_p1[AXIS_W-1:0] : '0;
  assign DMA_AXIS_tlast  = vld_p1 && slast_p1 && (beat_p1 == BW'(BPF-1));
  assign DMA_AXIS_tkeep  = '1;
  assign st_clr          = (state != IDLE);

endmodule
